// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory with a ready handshake; outputs decode from state and op.
module multicycle_ctrl #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           iord,
  output logic           irwrite,
  output logic           pcwrite,
  output logic           branch,
  output logic           bne,
  output logic [1:0]     pcsrc,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     aluop,
  output logic [1:0]     regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           memwrite,
  output logic           jal,
  output logic           lb,
  output logic           sb,
  output logic           illegal,
  output logic [STW-1:0] state
);

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_LB   = OPW'(6'b100000);
  localparam logic [OPW-1:0] OP_SB   = OPW'(6'b101000);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_SLTI = OPW'(6'b001010);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b000011);

  typedef enum logic [STW-1:0] {
    FETCH   = STW'(0),
    DECODE  = STW'(1),
    MEMADR  = STW'(2),
    MEMRD   = STW'(3),
    MEMWB   = STW'(4),
    MEMWR   = STW'(5),
    EXEC    = STW'(6),
    ALUWB   = STW'(7),
    BRANCH  = STW'(8),
    IEXEC   = STW'(9),
    IWB     = STW'(10),
    JUMP    = STW'(11),
    JALS    = STW'(12),
    ILLEGAL = STW'(13)
  } state_t;

  state_t st, nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= FETCH;
    else        st <= nx;
  end

  always_comb begin
    nx       = st;
    mem_req  = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    pcsrc    = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    regdst   = 2'b00;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    jal      = 1'b0;
    lb       = 1'b0;
    sb       = 1'b0;
    illegal  = 1'b0;
    state    = st;
    case (st)
      FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) nx = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        unique case (op)
          OP_R:                       nx = EXEC;
          OP_LW, OP_SW, OP_LB, OP_SB: nx = MEMADR;
          OP_BEQ, OP_BNE:             nx = BRANCH;
          OP_ADDI, OP_SLTI:           nx = IEXEC;
          OP_J:                       nx = JUMP;
          OP_JAL:                     nx = JALS;
          default:                    nx = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nx = (op == OP_LW || op == OP_LB) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        lb      = (op == OP_LB);
        if (mem_ready) nx = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        lb       = (op == OP_LB);
        nx       = FETCH;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        sb       = (op == OP_SB);
        if (mem_ready) nx = FETCH;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        nx      = ALUWB;
      end
      ALUWB: begin
        regdst   = 2'b01;
        regwrite = 1'b1;
        nx       = FETCH;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = (op == OP_BEQ);
        bne     = (op == OP_BNE);
        nx      = FETCH;
      end
      IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = (op == OP_SLTI) ? 2'b11 : 2'b00;
        nx      = IWB;
      end
      IWB: begin
        regwrite = 1'b1;
        nx       = FETCH;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        nx      = FETCH;
      end
      // r31 takes the PC+4 already in PC while PC loads the target
      JALS: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        regdst   = 2'b10;
        regwrite = 1'b1;
        jal      = 1'b1;
        nx       = FETCH;
      end
      ILLEGAL: begin
        illegal = 1'b1;
      end
      default: nx = FETCH;
    endcase
    // reset low masks every output, not just the state register
    if (!reset) begin
      mem_req  = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      bne      = 1'b0;
      pcsrc    = 2'b00;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluop    = 2'b00;
      regdst   = 2'b00;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      jal      = 1'b0;
      lb       = 1'b0;
      sb       = 1'b0;
      illegal  = 1'b0;
      state    = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class and
// checks states and control outputs against hand-derived values.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req, iord, irwrite, pcwrite, branch, bne;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb, aluop, regdst;
  logic       memtoreg, regwrite, memwrite, jal, lb, sb, illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.OPW(6), .STW(4)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .bne(bne),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .memwrite(memwrite), .jal(jal),
    .lb(lb), .sb(sb), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  wire [25:0] allout = {mem_req, iord, irwrite, pcwrite, branch, bne,
                        pcsrc, alusrca, alusrcb, aluop, regdst,
                        memtoreg, regwrite, memwrite, jal, lb, sb,
                        illegal, state};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    op = 6'b000000;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("rst_zero", 32'(allout), 32'h0);
    end
    reset = 1'b1;
    #1;
    chk("f_state", 32'(state), 0);
    chk("f_memreq", 32'(mem_req), 1);
    chk("f_irwrite", 32'(irwrite), 1);
    chk("f_pcwrite", 32'(pcwrite), 1);
    chk("f_alusrcb", 32'(alusrcb), 1);
    chk("f_iord", 32'(iord), 0);

    // R-type
    nxt(); chk("r_s1", 32'(state), 1);
    chk("r_dec_srcb", 32'(alusrcb), 3);
    nxt(); chk("r_s6", 32'(state), 6);
    chk("r_aluop", 32'(aluop), 2);
    nxt(); chk("r_s7", 32'(state), 7);
    chk("r_regwrite", 32'(regwrite), 1);
    chk("r_regdst", 32'(regdst), 1);
    nxt(); chk("r_s0", 32'(state), 0);

    // LB with two stall cycles
    op = 6'b100000;
    nxt(); chk("lb_s1", 32'(state), 1);
    nxt(); chk("lb_s2", 32'(state), 2);
    chk("lb_srcb", 32'(alusrcb), 2);
    nxt(); chk("lb_s3a", 32'(state), 3);
    mem_ready = 1'b0;
    chk("lb_lb3", 32'(lb), 1);
    chk("lb_mtr3", 32'(memtoreg), 0);
    chk("lb_iord3", 32'(iord), 1);
    nxt(); chk("lb_s3b", 32'(state), 3);
    nxt(); chk("lb_s3c", 32'(state), 3);
    mem_ready = 1'b1;
    nxt(); chk("lb_s4", 32'(state), 4);
    chk("lb_lb4", 32'(lb), 1);
    chk("lb_mtr4", 32'(memtoreg), 1);
    chk("lb_rw4", 32'(regwrite), 1);
    nxt(); chk("lb_s0", 32'(state), 0);
    chk("lb_mtr0", 32'(memtoreg), 0);

    // SB
    op = 6'b101000;
    nxt(); chk("sb_s1", 32'(state), 1);
    nxt(); chk("sb_s2", 32'(state), 2);
    nxt(); chk("sb_s5", 32'(state), 5);
    chk("sb_mw", 32'(memwrite), 1);
    chk("sb_sb", 32'(sb), 1);
    chk("sb_iord", 32'(iord), 1);
    nxt(); chk("sb_s0", 32'(state), 0);

    // BNE then JAL
    op = 6'b000101;
    nxt(); chk("bne_s1", 32'(state), 1);
    nxt(); chk("bne_s8", 32'(state), 8);
    chk("bne_bne", 32'(bne), 1);
    chk("bne_branch", 32'(branch), 0);
    chk("bne_pcsrc", 32'(pcsrc), 1);
    chk("bne_aluop", 32'(aluop), 1);
    nxt(); chk("bne_s0", 32'(state), 0);
    op = 6'b000011;
    nxt(); chk("jal_s1", 32'(state), 1);
    nxt(); chk("jal_s12", 32'(state), 12);
    chk("jal_regdst", 32'(regdst), 2);
    chk("jal_jal", 32'(jal), 1);
    chk("jal_pcwrite", 32'(pcwrite), 1);
    chk("jal_pcsrc", 32'(pcsrc), 2);
    chk("jal_rw", 32'(regwrite), 1);
    nxt(); chk("jal_s0", 32'(state), 0);

    // SLTI, with a fetch stall first
    op = 6'b001010;
    mem_ready = 1'b0;
    #1;
    chk("stall_irw", 32'(irwrite), 0);
    chk("stall_pcw", 32'(pcwrite), 0);
    nxt(); chk("stall_s0", 32'(state), 0);
    mem_ready = 1'b1;
    nxt(); chk("slti_s1", 32'(state), 1);
    nxt(); chk("slti_s9", 32'(state), 9);
    chk("slti_aluop", 32'(aluop), 3);
    nxt(); chk("slti_s10", 32'(state), 10);
    chk("slti_rw", 32'(regwrite), 1);
    chk("slti_regdst", 32'(regdst), 0);
    nxt(); chk("slti_s0", 32'(state), 0);

    // SW, reset mid-wait drops memwrite at once
    op = 6'b101011;
    nxt(); chk("sw_s1", 32'(state), 1);
    nxt(); chk("sw_s2", 32'(state), 2);
    mem_ready = 1'b0;
    nxt(); chk("sw_s5", 32'(state), 5);
    chk("sw_sb", 32'(sb), 0);
    nxt(); chk("sw_wait", 32'(state), 5);
    chk("sw_mw_wait", 32'(memwrite), 1);
    reset = 1'b0;
    #1;
    chk("sw_rst_mw", 32'(memwrite), 0);
    chk("sw_rst_st", 32'(dut.st), 0);
    mem_ready = 1'b1;
    nxt();
    reset = 1'b1;
    #1;
    chk("sw_restart", 32'(state), 0);

    // illegal opcode is absorbing
    op = 6'b111111;
    nxt(); chk("ill_s1", 32'(state), 1);
    nxt(); chk("ill_s13", 32'(state), 13);
    for (int i = 0; i < 10; i++) begin
      mem_ready = ~mem_ready;
      nxt();
      chk("ill_hold", 32'(state), 13);
      chk("ill_flag", 32'(illegal), 1);
    end
    reset = 1'b0;
    #1;
    chk("ill_rst_st", 32'(dut.st), 0);
    chk("ill_rst_flag", 32'(illegal), 0);
    chk("ill_rst_all", 32'(allout), 0);
    nxt();
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("ill_restart", 32'(state), 0);
    chk("ill_restart_mr", 32'(mem_req), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
